// File: rtl/el2_pkg.sv
// rtl/el2_pkg.sv - shared LSU/trigger packet types and trigger counter defaults
package el2_pkg;

   localparam int EL2_TRIG_CNT_W = 8;

   typedef struct packed {
      logic        select;
      logic        match;
      logic        store;
      logic        load;
      logic        m;
      logic [31:0] tdata2;
   } el2_trigger_pkt_t;

   typedef struct packed {
      logic valid;
      logic dma;
      logic store;
      logic load;
      logic word;
      logic half;
      logic by;
   } el2_lsu_pkt_t;

   // Store data as the triggers see it: only the lanes the access actually writes.
   function automatic logic [31:0] el2_store_lane(input el2_lsu_pkt_t pkt, input logic [31:0] data);
      if (pkt.word)
         return data;
      else if (pkt.half)
         return {16'h0, data[15:0]};
      else if (pkt.by)
         return {24'h0, data[7:0]};
      else
         return 32'h0;
   endfunction

endpackage

// File: rtl/el2_lsu_trig_cnt.sv
// rtl/el2_lsu_trig_cnt.sv - per-trigger hit threshold, counter and sticky hit status
module el2_lsu_trig_cnt
   import el2_pkg::*;
#(
   parameter int CNT_W = EL2_TRIG_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             qual,
   input  logic             flush,
   input  logic             cfg_wen,
   input  logic [CNT_W-1:0] cfg_thr,
   input  logic             hit_clr,
   output logic             fire,
   output logic [CNT_W-1:0] cnt,
   output logic             hit
);

   logic [CNT_W-1:0] thr;
   logic [CNT_W:0]   thr_eff;
   logic [CNT_W:0]   cnt_nxt;

   // Extra bit keeps cnt+1 from wrapping at the top of the counter range.
   assign thr_eff = (thr == '0) ? (CNT_W+1)'(1) : {1'b0, thr};
   assign cnt_nxt = {1'b0, cnt} + (CNT_W+1)'(1);
   assign fire    = ~rst & qual & ~flush & (cnt_nxt >= thr_eff);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         thr <= CNT_W'(1);
         cnt <= '0;
         hit <= 1'b0;
      end else begin
         if (cfg_wen) begin
            thr <= cfg_thr;
            cnt <= '0;
         end else if (qual & ~flush) begin
            cnt <= fire ? '0 : cnt_nxt[CNT_W-1:0];
         end
         hit <= fire | (hit & ~hit_clr);
      end
   end

endmodule

// File: rtl/rvmaskandmatch.sv
// rtl/rvmaskandmatch.sv - exact or NAPOT-style masked compare of data against a trigger value
module rvmaskandmatch #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] mask,
   input  logic [WIDTH-1:0] data,
   input  logic             masken,
   output logic             match
);

   logic [WIDTH-1:0] matchvec;
   logic             masken_or_fullmask;

   assign masken_or_fullmask = masken & ~(&mask);
   assign matchvec[0]        = masken_or_fullmask | (mask[0] == data[0]);

   // Bit i is don't-care when every lower mask bit is one (trailing-ones range encoding).
   for (genvar i = 1; i < WIDTH; i++) begin : g_bit
      assign matchvec[i] = (&mask[i-1:0] & masken_or_fullmask) | (mask[i] == data[i]);
   end

   assign match = &matchvec;

endmodule

// File: rtl/el2_lsu_trigger_cnt.sv
// rtl/el2_lsu_trigger_cnt.sv - M-stage load/store triggers with chaining and hit-count thresholds
module el2_lsu_trigger_cnt
   import el2_pkg::*;
#(
   parameter int NUM_TRIG = 4,
   parameter int CNT_W    = EL2_TRIG_CNT_W,
   parameter int IDX_W    = $clog2(NUM_TRIG)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  el2_trigger_pkt_t [NUM_TRIG-1:0]   trigger_pkt_any,
   input  logic [NUM_TRIG-1:0]               trig_chain,
   input  logic                              trig_cfg_wen,
   input  logic [IDX_W-1:0]                  trig_cfg_idx,
   input  logic [CNT_W-1:0]                  trig_cfg_thr,
   input  el2_lsu_pkt_t                      lsu_pkt_m,
   input  logic [31:0]                       lsu_addr_m,
   input  logic [31:0]                       store_data_m,
   input  logic                              lsu_flush_m,
   input  logic [NUM_TRIG-1:0]               hit_clr,
   output logic [NUM_TRIG-1:0]               lsu_trigger_match_m,
   output logic [NUM_TRIG-1:0]               lsu_trigger_hit_r,
   output logic [NUM_TRIG*CNT_W-1:0]         trig_cnt_r
);

   logic                trigger_enable;
   logic [31:0]         addr_gated;
   logic [31:0]         store_data_lane;
   logic [NUM_TRIG-1:0] raw;

   always_comb begin
      trigger_enable = 1'b0;
      for (int i = 0; i < NUM_TRIG; i++)
         trigger_enable = trigger_enable | trigger_pkt_any[i].m;
   end

   // Operands held at zero while no trigger is armed so the comparators stay quiet.
   assign addr_gated      = {32{trigger_enable}} & lsu_addr_m;
   assign store_data_lane = {32{trigger_enable}} & el2_store_lane(lsu_pkt_m, store_data_m);

   for (genvar i = 0; i < NUM_TRIG; i++) begin : g_trig
      logic [31:0] operand;
      logic        mask_hit;
      logic        fwd;
      logic        bwd;
      logic        nxt_bwd;
      logic        qual;

      assign operand = trigger_pkt_any[i].select ?
                       ({32{trigger_pkt_any[i].store}} & store_data_lane) : addr_gated;

      rvmaskandmatch #(.WIDTH(32)) u_match (
         .mask   (trigger_pkt_any[i].tdata2),
         .data   (operand),
         .masken (trigger_pkt_any[i].match),
         .match  (mask_hit)
      );

      assign raw[i] = trigger_enable & lsu_pkt_m.valid & ~lsu_pkt_m.dma & mask_hit &
                      ((trigger_pkt_any[i].store & lsu_pkt_m.store) |
                       (trigger_pkt_any[i].load & lsu_pkt_m.load & ~trigger_pkt_any[i].select));

      // fwd ANDs raw from the group start up to i, bwd from i to the group end.
      if (i == 0) begin : g_first
         assign fwd = raw[i];
      end else begin : g_rest
         assign fwd = raw[i] & (~trig_chain[i-1] | g_trig[i-1].fwd);
      end

      if (i == NUM_TRIG-1) begin : g_last
         assign nxt_bwd = 1'b1;
      end else begin : g_mid
         assign nxt_bwd = g_trig[i+1].bwd;
      end

      assign bwd  = raw[i] & (~trig_chain[i] | nxt_bwd);
      assign qual = fwd & bwd;

      el2_lsu_trig_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .qual    (qual),
         .flush   (lsu_flush_m),
         .cfg_wen (trig_cfg_wen & (trig_cfg_idx == IDX_W'(i))),
         .cfg_thr (trig_cfg_thr),
         .hit_clr (hit_clr[i]),
         .fire    (lsu_trigger_match_m[i]),
         .cnt     (trig_cnt_r[i*CNT_W +: CNT_W]),
         .hit     (lsu_trigger_hit_r[i])
      );
   end

endmodule

// File: doc/el2_lsu_trigger_cnt.md
# el2_lsu_trigger_cnt

Parametrised LSU data/address trigger unit with chaining, per-trigger hit-count thresholds and sticky hit status. It sits in the LSU M stage beside the address/store-data path, evaluates NUM_TRIG debug triggers against each load/store, and reports qualified matches to dec in the same cycle. Registered hit status and counters are kept for the debug CSR path.

## Interface
- NUM_TRIG, 4, number of triggers (2..8)
- CNT_W, 8, width of per-trigger hit counter and threshold
- IDX_W, $clog2(NUM_TRIG), config index width (derived, not overridden)
- clk  in  1  core clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- trigger_pkt_any  in  el2_trigger_pkt_t[NUM_TRIG-1:0]  trigger config from dec (select, match, store, load, m, tdata2)
- trig_chain  in  NUM_TRIG  chain[i]=1 links trigger i to i+1; chain[NUM_TRIG-1] ignored
- trig_cfg_wen  in  1  threshold write strobe
- trig_cfg_idx  in  IDX_W  threshold write index
- trig_cfg_thr  in  CNT_W  threshold value; 0 treated as 1
- lsu_pkt_m  in  el2_lsu_pkt_t  M-stage packet
- lsu_addr_m  in  32  access address
- store_data_m  in  32  store data
- lsu_flush_m  in  1  kill M-stage access
- hit_clr  in  NUM_TRIG  clear sticky hit bits
- lsu_trigger_match_m  out  NUM_TRIG  qualified fire, combinational in M
- lsu_trigger_hit_r  out  NUM_TRIG  sticky hit status
- trig_cnt_r  out  NUM_TRIG*CNT_W  current counters, trigger i at [i*CNT_W +: CNT_W]

## Operation
- trigger_enable = OR of trigger_pkt_any[i].m; when 0, address/data operands forced to 0 (power), no outputs fire, no counters move.
- Store data lane-masked: word = all 32 bits; half = [15:0], upper zero; byte = [7:0], upper zero.
- Operand i: address when select=0; masked store data when select=1 and store=1; else 0.
- raw[i] = valid & ~dma & ((store_i & pkt.store) | (load_i & pkt.load & ~select_i)) & maskmatch(tdata2_i, operand_i, match_i).
- Chain groups: maximal runs of triggers linked by trig_chain. qual[i] = AND of raw over all members of i's group; unchained trigger is a group of one.
- Threshold thr[i] registered, reset 1. Counter cnt[i] registered, reset 0; invariant cnt[i] < max(thr[i],1).
- fire[i] = qual[i] & ~lsu_flush_m & (cnt[i]+1 >= max(thr[i],1)); compare done in CNT_W+1 bits, no wrap.
- lsu_trigger_match_m[i] = fire[i].
- Counter update on qual & ~flush: fire → cnt=0; else cnt+1. No qual or flushed → hold.
- Threshold write: thr[idx]=trig_cfg_thr, cnt[idx]=0; write wins over a same-cycle counter update on that index. Current-cycle fire uses old thr/cnt.
- Sticky: hit_r[i] set on fire[i]; cleared by hit_clr[i]; set wins over simultaneous clear.
- DMA, invalid, or flushed accesses never count or fire.

## Timing
- lsu_trigger_match_m: 0-cycle, combinational from M inputs and registered state.
- cnt, thr, hit_r update at next clk rising edge; hit_r visible 1 cycle after fire.
- Reset (async assert, any time including mid-count): cnt=0, thr=1, hit_r=0; lsu_trigger_match_m=0 while rst high. First post-reset access with a match fires immediately (thr=1).
- No handshake; one access per cycle max.

## Structure
- el2_trigger_pkt_t and el2_lsu_pkt_t remain in el2_pkg; add EL2_TRIG_CNT_W default constant to el2_pkg.
- Sub-module el2_lsu_trig_cnt: one per trigger, holds thr/cnt/hit_r, inputs qual, flush, cfg write, hit_clr; outputs fire, cnt, hit.
- Mask compare reuses rvmaskandmatch; chain-group AND is a generate loop in the top.

## Test plan
- thr all 1, trigger0 store addr tdata2=0x8000_0010, match=0, SW to 0x8000_0010 → match_m=0001 same cycle, hit_r=0001 next cycle.
- thr[1]=3, load addr match on trigger1, three loads → match_m[1] on 3rd only; cnt 1,2,0.
- chain[0]=1, trig0 addr, trig1 store data 0xA5 byte; SB 0xA5 to match addr → match_m=0011; wrong data → 0000, counters unchanged.
- Matching access with lsu_flush_m=1, or dma=1 → match_m=0, cnt held; hit_clr with simultaneous fire → hit_r stays 1.
- thr[2]=4, two matches then cfg write thr=2 idx 2 with a match same cycle → no fire, cnt[2]=0; next two matches fire on 2nd.
- Assert rst mid-count (cnt[1]=2) → cnt=0, thr=1, hit_r=0 immediately; next match fires.
